// File: rtl/bus_cycle_ack_pkg.sv
// Shared decode constants for the bus-cycle acknowledge path.
// Covers device positions, port widths, per-device wait states, the ext-ready mask and the FSM encoding.
package bus_cycle_ack_pkg;

  localparam int DEVICE_SELECTED_MAXPOS = 13;

  localparam int DEVICE_ROM_POS        = 0;
  localparam int DEVICE_QUART_POS      = 1;
  localparam int DEVICE_REGISTER8_POS  = 2;
  localparam int DEVICE_REGISTER16_POS = 3;
  localparam int DEVICE_REGISTER32_POS = 4;
  localparam int DEVICE_SIMM_POS       = 5;
  localparam int DEVICE_SLOT0_POS      = 6;
  localparam int DEVICE_SLOT1_POS      = 7;
  localparam int DEVICE_SLOT2_POS      = 8;
  localparam int DEVICE_SLOT3_POS      = 9;
  localparam int DEVICE_IDE1_POS       = 10;
  localparam int DEVICE_IDE3_POS       = 11;
  localparam int DEVICE_ETH_POS        = 12;

  localparam logic [DEVICE_SELECTED_MAXPOS-1:0] DEVICE_NULL = '0;

  localparam int PORT_WIDTH_WIDTH = 2;
  localparam logic [PORT_WIDTH_WIDTH-1:0] PORT_WIDTH_NULL = 2'd0;
  localparam logic [PORT_WIDTH_WIDTH-1:0] PORT_WIDTH_BYTE = 2'd1;
  localparam logic [PORT_WIDTH_WIDTH-1:0] PORT_WIDTH_WORD = 2'd2;
  localparam logic [PORT_WIDTH_WIDTH-1:0] PORT_WIDTH_LONG = 2'd3;

  localparam int WAIT_W = 2;

  // Indexed by device position; IDE and ETH rely on external ready only.
  localparam logic [WAIT_W-1:0] WAIT_STATES [DEVICE_SELECTED_MAXPOS] = '{
    2'd2, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0
  };

  localparam logic [DEVICE_SELECTED_MAXPOS-1:0] EXT_READY_MASK =
    (13'(1) << DEVICE_SLOT0_POS) | (13'(1) << DEVICE_SLOT1_POS) |
    (13'(1) << DEVICE_SLOT2_POS) | (13'(1) << DEVICE_SLOT3_POS) |
    (13'(1) << DEVICE_IDE1_POS)  | (13'(1) << DEVICE_IDE3_POS)  |
    (13'(1) << DEVICE_ETH_POS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_BERR = 2'd3
  } state_t;

  function automatic logic [WAIT_W-1:0] wait_states_of(input logic [DEVICE_SELECTED_MAXPOS-1:0] dev);
    logic [WAIT_W-1:0] w;
    w = '0;
    for (int i = 0; i < DEVICE_SELECTED_MAXPOS; i++) begin
      if (dev[i]) w = w | WAIT_STATES[i];
    end
    return w;
  endfunction

endpackage

// File: rtl/bus_cycle_ack_watchdog.sv
// Bus-error watchdog: counts clocks spent waiting and flags expiry at TIMEOUT_CYCLES.
// Present only when BUS_TIMEOUT_EN is defined; otherwise o_expired is constant 0.
module bus_watchdog #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TIMEOUT_WIDTH  = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expired
);

`ifdef BUS_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] r_count;

  assign o_expired = (r_count == TIMEOUT_WIDTH'(TIMEOUT_CYCLES));

  // Saturates at the limit so a long stall cannot wrap back below it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_run && !o_expired) begin
      r_count <= r_count + 1'b1;
    end
  end
`else
  logic w_unused;
  assign w_unused  = ^{clock, reset, i_clear, i_run, TIMEOUT_WIDTH'(TIMEOUT_CYCLES)};
  assign o_expired = 1'b0;
`endif

endmodule

// File: rtl/bus_cycle_ack.sv
// 68030 bus-cycle acknowledge generator: registered DSACK/AVEC/BERR with wait states and ext ready.
// Define BUS_TIMEOUT_EN to include the bus-error watchdog and BERR termination.
module bus_cycle_ack
  import bus_cycle_ack_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TIMEOUT_WIDTH  = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              as,
  input  logic                              function_int_ack_selected,
  input  logic [DEVICE_SELECTED_MAXPOS-1:0] device_selected,
  input  logic [PORT_WIDTH_WIDTH-1:0]       port_width,
  input  logic [DEVICE_SELECTED_MAXPOS-1:0] device_ready,
  output logic [1:0]                        dsack,
  output logic                              avec,
  output logic                              berr,
  output logic                              busy
);

`ifdef BUS_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  state_t                            r_state;
  state_t                            w_next_state;
  logic [DEVICE_SELECTED_MAXPOS-1:0] r_dev;
  logic [PORT_WIDTH_WIDTH-1:0]       r_width;
  logic                              r_intack;
  logic [WAIT_W-1:0]                 r_wait_cnt;
  logic [1:0]                        r_dsack;
  logic                              r_avec;
  logic                              r_berr;
  logic                              r_busy;
  logic [DEVICE_SELECTED_MAXPOS-1:0] w_ext_sel;
  logic                              w_ack_ok;
  logic                              w_expired;
  logic                              w_start;

  assign w_start   = (r_state == ST_IDLE) && as;
  assign w_ext_sel = r_dev & EXT_READY_MASK;

  // Null device or null width never qualifies, so those cycles can only time out or abort.
  assign w_ack_ok = r_intack ||
                    ((r_dev != DEVICE_NULL) && (r_width != PORT_WIDTH_NULL) &&
                     ((w_ext_sel == '0) || ((w_ext_sel & device_ready) != '0)));

  bus_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMEOUT_WIDTH  (TIMEOUT_WIDTH)
  ) u_watchdog (
    .clock     (clock),
    .reset     (reset),
    .i_clear   (r_state == ST_IDLE),
    .i_run     (r_state == ST_WAIT),
    .o_expired (w_expired)
  );

  // Every cycle passes through WAIT; a zero-count cycle leaves it on its first clock.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (as) w_next_state = ST_WAIT;
      ST_WAIT: begin
        if (!as)                                w_next_state = ST_IDLE;
        else if ((r_wait_cnt == '0) && w_ack_ok) w_next_state = ST_ACK;
        else if (TIMEOUT_EN && w_expired)       w_next_state = ST_BERR;
      end
      ST_ACK:  if (!as) w_next_state = ST_IDLE;
      ST_BERR: if (!as) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change on the same edge as the state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_dev      <= '0;
      r_width    <= '0;
      r_intack   <= 1'b0;
      r_wait_cnt <= '0;
      r_dsack    <= 2'b00;
      r_avec     <= 1'b0;
      r_berr     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_start) begin
        r_dev      <= device_selected;
        r_width    <= port_width;
        r_intack   <= function_int_ack_selected;
        r_wait_cnt <= function_int_ack_selected ? '0 : wait_states_of(device_selected);
      end else if ((r_state == ST_WAIT) && (r_wait_cnt != '0)) begin
        r_wait_cnt <= r_wait_cnt - 1'b1;
      end
      r_dsack <= ((w_next_state == ST_ACK) && !r_intack) ? r_width : 2'b00;
      r_avec  <= (w_next_state == ST_ACK) && r_intack;
      r_berr  <= (w_next_state == ST_BERR);
      r_busy  <= (w_next_state != ST_IDLE);
    end
  end

  assign dsack = r_dsack;
  assign avec  = r_avec;
  assign berr  = TIMEOUT_EN ? r_berr : 1'b0;
  assign busy  = r_busy;

endmodule

// File: tb/tb_bus_cycle_ack.sv
// Directed bench for bus_cycle_ack: latency, wait states, ext ready, int-ack, abort, reset, timeout.
module tb_bus_cycle_ack;
  import bus_cycle_ack_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        as;
  logic        intack;
  logic [12:0] dev;
  logic [1:0]  pw;
  logic [12:0] rdy;
  logic [1:0]  dsack;
  logic        avec;
  logic        berr;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  bus_cycle_ack #(.TIMEOUT_CYCLES(16)) dut (
    .clock                     (clock),
    .reset                     (reset),
    .as                        (as),
    .function_int_ack_selected (intack),
    .device_selected           (dev),
    .port_width                (pw),
    .device_ready              (rdy),
    .dsack                     (dsack),
    .avec                      (avec),
    .berr                      (berr),
    .busy                      (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and return at the following falling edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  function automatic logic [12:0] onehot(input int pos);
    logic [12:0] v;
    v = 13'(1) << pos;
    return v;
  endfunction

  // Drives a cycle start and returns just after edge N (the edge that samples as=1).
  task automatic begin_cycle(input logic [12:0] d, input logic [1:0] w, input logic ia);
    dev    = d;
    pw     = w;
    intack = ia;
    as     = 1'b1;
    step(1);
  endtask

  task automatic end_cycle(input string tag);
    as     = 1'b0;
    dev    = '0;
    pw     = PORT_WIDTH_NULL;
    intack = 1'b0;
    rdy    = '0;
    step(1);
    check({tag, "_end_dsack"}, 32'(dsack), 32'd0);
    check({tag, "_end_busy"},  32'(busy),  32'd0);
  endtask

  initial begin
    reset  = 1'b1;
    as     = 1'b0;
    intack = 1'b0;
    dev    = '0;
    pw     = PORT_WIDTH_NULL;
    rdy    = '0;
    step(2);
    check("rst_dsack", 32'(dsack), 32'd0);
    check("rst_avec",  32'(avec),  32'd0);
    check("rst_berr",  32'(berr),  32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    reset = 1'b0;
    step(2);

    // Zero-wait LONG: dsack after edge N+1.
    begin_cycle(onehot(DEVICE_REGISTER32_POS), PORT_WIDTH_LONG, 1'b0);
    check("z_n_dsack", 32'(dsack), 32'd0);
    check("z_n_busy",  32'(busy),  32'd1);
    step(1);
    check("z_n1_dsack", 32'(dsack), 32'd3);
    step(3);
    check("z_hold_dsack", 32'(dsack), 32'd3);
    end_cycle("z");

    // Zero-wait BYTE.
    begin_cycle(onehot(DEVICE_REGISTER8_POS), PORT_WIDTH_BYTE, 1'b0);
    step(1);
    check("byte_dsack", 32'(dsack), 32'd1);
    end_cycle("byte");

    // ROM, 2 wait states, WORD; decode inputs changed mid-cycle must be ignored.
    begin_cycle(onehot(DEVICE_ROM_POS), PORT_WIDTH_WORD, 1'b0);
    dev = onehot(DEVICE_REGISTER32_POS);
    pw  = PORT_WIDTH_LONG;
    check("rom_n_dsack", 32'(dsack), 32'd0);
    step(1);
    check("rom_n1_dsack", 32'(dsack), 32'd0);
    step(1);
    check("rom_n2_dsack", 32'(dsack), 32'd0);
    step(1);
    check("rom_n3_dsack", 32'(dsack), 32'd2);
    end_cycle("rom");

    // QUART: 1 wait state, not ext-ready, ready low.
    begin_cycle(onehot(DEVICE_QUART_POS), PORT_WIDTH_BYTE, 1'b0);
    step(1);
    check("quart_n1_dsack", 32'(dsack), 32'd0);
    step(1);
    check("quart_n2_dsack", 32'(dsack), 32'd1);
    end_cycle("quart");

    // SLOT2 ext ready: another device's ready bit must not help.
    begin_cycle(onehot(DEVICE_SLOT2_POS), PORT_WIDTH_WORD, 1'b0);
    rdy = onehot(DEVICE_SLOT1_POS);
    step(5);
    check("slot_wait_dsack", 32'(dsack), 32'd0);
    check("slot_wait_busy",  32'(busy),  32'd1);
    rdy = onehot(DEVICE_SLOT2_POS);
    step(1);
    check("slot_rdy_dsack", 32'(dsack), 32'd2);
    end_cycle("slot");

    // Int-ack: avec one clock later, dsack stays 00.
    begin_cycle(DEVICE_NULL, PORT_WIDTH_NULL, 1'b1);
    check("ia_n_avec", 32'(avec), 32'd0);
    step(1);
    check("ia_avec",  32'(avec),  32'd1);
    check("ia_dsack", 32'(dsack), 32'd0);
    end_cycle("ia");
    check("ia_end_avec", 32'(avec), 32'd0);

    // Abort mid-WAIT: the pending ack is discarded.
    begin_cycle(onehot(DEVICE_ROM_POS), PORT_WIDTH_LONG, 1'b0);
    step(1);
    as = 1'b0;
    step(1);
    check("abort_dsack", 32'(dsack), 32'd0);
    check("abort_busy",  32'(busy),  32'd0);
    step(2);
    check("abort_late_dsack", 32'(dsack), 32'd0);

    // Reset pulse during ACK clears outputs before any clock edge.
    begin_cycle(onehot(DEVICE_REGISTER16_POS), PORT_WIDTH_LONG, 1'b0);
    step(1);
    check("rack_pre_dsack", 32'(dsack), 32'd3);
    #2 reset = 1'b1;
    #1;
    check("rack_dsack", 32'(dsack), 32'd0);
    check("rack_busy",  32'(busy),  32'd0);
    @(negedge clock);
    reset = 1'b0;
    end_cycle("rack");

    // Non-null device with NULL width is never acknowledged.
    begin_cycle(onehot(DEVICE_REGISTER32_POS), PORT_WIDTH_NULL, 1'b0);
    step(4);
    check("nw_dsack", 32'(dsack), 32'd0);
    check("nw_busy",  32'(busy),  32'd1);
    end_cycle("nw");

    // Null device: BERR after edge 17 of the cycle when the watchdog exists, else a WAIT stall.
    begin_cycle(DEVICE_NULL, PORT_WIDTH_LONG, 1'b0);
    step(16);
    check("to_e16_berr", 32'(berr), 32'd0);
    step(1);
`ifdef BUS_TIMEOUT_EN
    check("to_e17_berr", 32'(berr), 32'd1);
`else
    check("to_e17_berr", 32'(berr), 32'd0);
`endif
    check("to_dsack", 32'(dsack), 32'd0);
    check("to_busy",  32'(busy),  32'd1);
    step(3);
`ifdef BUS_TIMEOUT_EN
    check("to_hold_berr", 32'(berr), 32'd1);
`else
    check("to_hold_berr", 32'(berr), 32'd0);
`endif
    end_cycle("to");
    check("to_end_berr", 32'(berr), 32'd0);

    // Ready on the same edge the watchdog expires: ACK wins.
    begin_cycle(onehot(DEVICE_SLOT0_POS), PORT_WIDTH_LONG, 1'b0);
    step(16);
    check("co_e16_dsack", 32'(dsack), 32'd0);
    rdy = onehot(DEVICE_SLOT0_POS);
    step(1);
    check("co_dsack", 32'(dsack), 32'd3);
    check("co_berr",  32'(berr),  32'd0);
    end_cycle("co");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
